// File: rtl/fibo_pkg.sv
// Shared constants for the Fibonacci controller: FSM states, ALU opcodes and
// register-file indices of the 4-register datapath.
package fibo_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LD0,
        LD1,
        LD2,
        LD3,
        CHK,
        ADDA,
        DECA,
        ADDB,
        DECB,
        OUT
    } state_t;

    localparam logic [2:0] FIBO_OP_ADD   = 3'b000;
    localparam logic [2:0] FIBO_OP_SUB   = 3'b001;
    localparam logic [2:0] FIBO_OP_PASSA = 3'b010;

    // R0/R1 alternate Fibonacci terms, R2 counts down, R3 holds constant 1.
    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

endpackage

// File: rtl/fibo_controller.sv
// Moore controller sequencing a 4-register ALU datapath to compute F(n);
// the result is left on the datapath bus via a PASSA read of res_sel.
module fibo_controller
    import fibo_pkg::*;
#(
    parameter int unsigned size     = 4,
    parameter logic [2:0]  OP_ADD   = FIBO_OP_ADD,
    parameter logic [2:0]  OP_SUB   = FIBO_OP_SUB,
    parameter logic [2:0]  OP_PASSA = FIBO_OP_PASSA
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [size-1:0] n,
    input  logic            zero_flag,
    output logic [1:0]      wrt_addr,
    output logic            wrt_en,
    output logic            load_data,
    output logic [1:0]      rd_addr1,
    output logic [1:0]      rd_addr2,
    output logic [2:0]      alu_opcode,
    output logic [size-1:0] count,
    output logic            busy,
    output logic            done
);

    state_t          state, state_next;
    logic [1:0]      res_sel, res_sel_next;
    logic [size-1:0] n_latched, n_latched_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            res_sel   <= R1;
            n_latched <= '0;
        end else begin
            state     <= state_next;
            res_sel   <= res_sel_next;
            n_latched <= n_latched_next;
        end
    end

    // zero_flag is the combinational ALU flag of the operation issued this cycle.
    always_comb begin
        state_next     = state;
        res_sel_next   = res_sel;
        n_latched_next = n_latched;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = LD0;
                    n_latched_next = n;
                end
            end
            LD0:  state_next = LD1;
            LD1:  state_next = LD2;
            LD2:  state_next = LD3;
            LD3:  state_next = CHK;
            CHK: begin
                if (zero_flag) begin
                    res_sel_next = R1;
                    state_next   = OUT;
                end else begin
                    state_next   = ADDA;
                end
            end
            ADDA: state_next = DECA;
            DECA: begin
                if (zero_flag) begin
                    res_sel_next = R0;
                    state_next   = OUT;
                end else begin
                    state_next   = ADDB;
                end
            end
            ADDB: state_next = DECB;
            DECB: begin
                if (zero_flag) begin
                    res_sel_next = R1;
                    state_next   = OUT;
                end else begin
                    state_next   = ADDA;
                end
            end
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wrt_addr   = R0;
        wrt_en     = 1'b0;
        load_data  = 1'b0;
        rd_addr1   = res_sel;
        rd_addr2   = R0;
        alu_opcode = OP_PASSA;
        count      = '0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            LD0: begin
                wrt_addr  = R0;
                wrt_en    = 1'b1;
                load_data = 1'b1;
                count     = size'(1);
            end
            LD1: begin
                wrt_addr  = R1;
                wrt_en    = 1'b1;
                load_data = 1'b1;
            end
            LD2: begin
                wrt_addr  = R2;
                wrt_en    = 1'b1;
                load_data = 1'b1;
                count     = n_latched;
            end
            LD3: begin
                wrt_addr  = R3;
                wrt_en    = 1'b1;
                load_data = 1'b1;
                count     = size'(1);
            end
            CHK: begin
                alu_opcode = OP_SUB;
                rd_addr1   = R2;
                rd_addr2   = R1;
            end
            ADDA, ADDB: begin
                alu_opcode = OP_ADD;
                rd_addr1   = R0;
                rd_addr2   = R1;
                wrt_addr   = (state == ADDA) ? R0 : R1;
                wrt_en     = 1'b1;
            end
            DECA, DECB: begin
                alu_opcode = OP_SUB;
                rd_addr1   = R2;
                rd_addr2   = R3;
                wrt_addr   = R2;
                wrt_en     = 1'b1;
            end
            OUT: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fibo_controller.sv
// Directed bench: fibo_controller driving a behavioural 4-register ALU
// datapath, with latency and result values worked out by hand.
module tb_fibo_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] n;
    logic       zero_flag;
    logic [1:0] wrt_addr;
    logic       wrt_en;
    logic       load_data;
    logic [1:0] rd_addr1;
    logic [1:0] rd_addr2;
    logic [2:0] alu_opcode;
    logic [3:0] count;
    logic       busy;
    logic       done;

    logic [3:0] rf [4];
    logic [3:0] data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fibo_controller #(.size(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n          (n),
        .zero_flag  (zero_flag),
        .wrt_addr   (wrt_addr),
        .wrt_en     (wrt_en),
        .load_data  (load_data),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .alu_opcode (alu_opcode),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    always_comb begin
        case (alu_opcode)
            3'b000:  data = rf[rd_addr1] + rf[rd_addr2];
            3'b001:  data = rf[rd_addr1] - rf[rd_addr2];
            3'b010:  data = rf[rd_addr1];
            default: data = '0;
        endcase
        zero_flag = (data == 4'd0);
    end

    always @(posedge clk) begin
        if (wrt_en) rf[wrt_addr] <= load_data ? count : data;
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Runs one computation; optionally re-pulses start (n=3) at pulse_cyc.
    task automatic run(input logic [3:0] nv, input int exp_cyc,
                       input logic [3:0] exp_data, input int pulse_cyc);
        int cyc;
        int done_cyc;
        int busy_low;
        @(negedge clk);
        start = 1'b1;
        n     = nv;
        @(posedge clk); #1;
        start    = 1'b0;
        n        = 4'd0;
        cyc      = 1;
        done_cyc = -1;
        busy_low = 0;
        while (cyc <= 50 && done_cyc < 0) begin
            if (cyc == pulse_cyc) begin
                start = 1'b1;
                n     = 4'd3;
            end else begin
                start = 1'b0;
            end
            if (!busy) busy_low++;
            if (cyc == 3) begin
                check("ld2_count", count, nv);
                check("ld2_addr", wrt_addr, 2);
            end
            if (done) begin
                done_cyc = cyc;
                check("done_data", data, exp_data);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("latency", done_cyc, exp_cyc);
        check("busy_during_run", busy_low, 0);
        check("idle_after_done", busy, 0);
        @(posedge clk); #1;
        check("idle_hold_data", data, exp_data);
        check("idle_no_done", done, 0);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        start = 1'b0;
        n     = 4'd0;
        #12;
        check("rst_wrt_en", wrt_en, 0);
        check("rst_load_data", load_data, 0);
        check("rst_count", count, 0);
        check("rst_rd_addr1", rd_addr1, 1);
        check("rst_rd_addr2", rd_addr2, 0);
        check("rst_opcode", alu_opcode, 2);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(4'd0, 6, 4'd0, -1);
        run(4'd1, 8, 4'd1, -1);
        run(4'd7, 20, 4'd13, -1);
        run(4'd8, 22, 4'd5, -1);
        run(4'd7, 20, 4'd13, 4);

        // Abort an n=7 run with reset in cycle 10.
        @(negedge clk);
        start = 1'b1;
        n     = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_wrt_en", wrt_en, 0);
        check("abort_busy", busy, 0);
        check("abort_opcode", alu_opcode, 2);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done || wrt_en) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check("abort_quiet", pulses, 0);
        run(4'd5, 16, 4'd5, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
